// File: rtl/pu_mac_pipe.sv
// pu_mac_pipe: N_CH-channel unsigned multiply-accumulate pipeline.
// S1 registers the per-channel products, S2 registers the full-precision
// adder-tree sum, and S3 folds the sum into a saturating frame accumulator
// and the output registers. One global advance signal stalls every stage
// while a result is pending and downstream is not ready.
module pu_mac_pipe #(
  parameter int DATA_W = 5,
  parameter int N_CH   = 4,
  parameter int ACC_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH*DATA_W-1:0]   in_weight,
  input  logic                     in_last,
  input  logic                     acc_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic                     out_ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(N_CH);

  // Adds the tree sum to the accumulator; returns {saturated, clamped value}.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [SUM_W-1:0] b);
    logic [ACC_W:0] raw;
    raw = {1'b0, a} + (ACC_W+1)'(b);
    if (raw[ACC_W]) begin
      sat_add = {1'b1, {ACC_W{1'b1}}};
    end else begin
      sat_add = raw;
    end
  endfunction

  logic              advance_s;
  logic [PROD_W-1:0] prod_s [N_CH];
  logic [PROD_W-1:0] prod_r [N_CH];
  logic              s1_valid_r;
  logic              s1_last_r;
  logic              s1_mode_r;
  logic [SUM_W-1:0]  sum_s;
  logic [SUM_W-1:0]  s2_sum_r;
  logic              s2_valid_r;
  logic              s2_last_r;
  logic              s2_mode_r;
  logic [ACC_W-1:0]  acc_r;
  logic              ovf_acc_r;
  logic [ACC_W:0]    add_s;
  logic [ACC_W-1:0]  total_s;
  logic              ovf_next_s;
  logic              term_s;

  // Whole pipeline moves only when no result is blocked at the output; nothing
  // is accepted while reset is held.
  always_comb begin
    advance_s = !rst && !(out_valid && !out_ready);
    in_ready  = advance_s;
  end

  // Per-channel unsigned products of the incoming beat.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      prod_s[k] = PROD_W'(in_data[k*DATA_W +: DATA_W]) *
                  PROD_W'(in_weight[k*DATA_W +: DATA_W]);
    end
  end

  // S1: capture products plus the beat's framing controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_mode_r  <= 1'b0;
      for (int k = 0; k < N_CH; k++) prod_r[k] <= '0;
    end else if (advance_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_last_r <= in_last;
        s1_mode_r <= acc_mode;
        for (int k = 0; k < N_CH; k++) prod_r[k] <= prod_s[k];
      end
    end
  end

  // Full-precision adder tree over the S1 products.
  always_comb begin
    sum_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      sum_s = sum_s + SUM_W'(prod_r[k]);
    end
  end

  // S2: capture the channel sum and forward the framing controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_sum_r   <= '0;
      s2_last_r  <= 1'b0;
      s2_mode_r  <= 1'b0;
    end else if (advance_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_sum_r  <= sum_s;
        s2_last_r <= s1_last_r;
        s2_mode_r <= s1_mode_r;
      end
    end
  end

  // S3 arithmetic: saturating running total and sticky overflow; a beat ends
  // its frame when it is a single-beat (mode 0) beat or carries in_last.
  always_comb begin
    add_s      = sat_add(acc_r, s2_sum_r);
    total_s    = add_s[ACC_W-1:0];
    ovf_next_s = ovf_acc_r | add_s[ACC_W];
    term_s     = !s2_mode_r || s2_last_r;
  end

  // S3: update accumulator, publish finished frames, retire accepted results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r     <= '0;
      ovf_acc_r <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance_s) begin
      if (s2_valid_r && term_s) begin
        out_data  <= total_s;
        out_ovf   <= ovf_next_s;
        out_valid <= 1'b1;
        acc_r     <= '0;
        ovf_acc_r <= 1'b0;
      end else if (s2_valid_r) begin
        acc_r     <= total_s;
        ovf_acc_r <= ovf_next_s;
        out_valid <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pu_mac_pipe.sv
// tb_pu_mac_pipe: scenario tasks with a frame-level reference model of the
// dot-product accumulator (DATA_W=5, N_CH=4, ACC_W=16).
module tb_pu_mac_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_data;
  logic [19:0] in_weight;
  logic        in_last;
  logic        acc_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [16:0] exp_q [$];
  logic [16:0] obs_q [$];
  int          obs_cyc [$];
  int          m_acc = 0;
  bit          m_ovf = 1'b0;

  pu_mac_pipe #(.DATA_W(5), .N_CH(4), .ACC_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weight(in_weight), .in_last(in_last),
    .acc_mode(acc_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result that the next rising edge hands downstream.
  always @(negedge clk) begin
    #2;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      obs_q.push_back({out_ovf, out_data});
      obs_cyc.push_back(cyc);
    end
  end

  // Frame model: dot product, running sum, clamp to 16 bits, sticky overflow.
  task automatic model_accept(input logic [19:0] d, input logic [19:0] w,
                              input logic last, input logic mode);
    int p = 0;
    int t;
    bit o;
    for (int k = 0; k < 4; k++) p += int'(d[k*5 +: 5]) * int'(w[k*5 +: 5]);
    t = m_acc + p;
    o = m_ovf || (t > 65535);
    if (t > 65535) t = 65535;
    if (!mode || last) begin
      exp_q.push_back({o, 16'(t)});
      m_acc = 0;
      m_ovf = 1'b0;
    end else begin
      m_acc = t;
      m_ovf = o;
    end
  endtask

  // Offer one beat from a falling edge until accepted; returns on the falling
  // edge after the accepting rising edge, leaving in_valid asserted.
  task automatic send(input logic [19:0] d, input logic [19:0] w,
                      input logic last, input logic mode);
    int b = 0;
    in_valid = 1'b1; in_data = d; in_weight = w; in_last = last; acc_mode = mode;
    #1;
    while (in_ready !== 1'b1 && b < 200) begin
      @(negedge clk); #1; b++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_timeout: in_ready=%b required=1", in_ready);
    end else begin
      model_accept(d, w, last, mode);
    end
    @(negedge clk);
  endtask

  // Stop offering, let the pipeline empty, then report whether counts agree.
  task automatic drain(output bit ok);
    int b = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (obs_q.size() < exp_q.size() && b < 300) begin
      @(negedge clk); #3; b++;
    end
    repeat (4) @(negedge clk);
    #3;
    ok = (obs_q.size() == exp_q.size());
    @(negedge clk);
  endtask

  task automatic clear_queues();
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_weight = '0;
    in_last = 1'b0; acc_mode = 1'b0; out_ready = 1'b1;
    #2;
    total++;
    if (out_valid !== 1'b0 || out_data !== 16'd0 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b data=%0d ovf=%b required 0/0/0",
               out_valid, out_data, out_ovf);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_in_ready: got %b required 0", in_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL release_in_ready: got %b required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    out_ready = 1'b1;
    send({5'd4, 5'd3, 5'd2, 5'd1}, {5'd8, 5'd7, 5'd6, 5'd5}, 1'b0, 1'b0);
    in_valid = 1'b0;
    // Three register stages: the result appears after the second edge that
    // follows the accepting edge (the third edge counting acceptance).
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL latency_edge1: out_valid=%b required 0", out_valid);
    end
    @(negedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL latency_edge2: out_valid=%b required 0", out_valid);
    end
    @(negedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'd70 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL latency_edge3: valid=%b data=%0d ovf=%b required 1/70/0",
               out_valid, out_data, out_ovf);
    end
    drain(ok);
    total++;
    if (!ok || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL single_result: got %0d results required 1 matching model", obs_q.size());
    end
    clear_queues();
  endtask

  task automatic test_accum();
    bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send({4{5'd31}}, {4{5'd31}}, (i == 2), 1'b1);
    drain(ok);
    total++;
    if (!ok || obs_q.size() != 1 || obs_q[0] !== {1'b0, 16'd11532}) begin
      bad++;
      $display("FAIL accum_3beat: count=%0d first=%h required one result 0x02d0c",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 17'h0);
    end
    clear_queues();
  endtask

  task automatic test_stall();
    bit ok;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(20'($urandom), 20'($urandom), 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        logic [15:0] v0;
        int b = 0;
        @(negedge clk); #1;
        while (out_valid !== 1'b1 && b < 50) begin
          @(negedge clk); #1; b++;
        end
        v0 = out_data;
        total++;
        if (out_valid !== 1'b1 || exp_q.size() == 0 || v0 !== exp_q[0][15:0]) begin
          bad++; $display("FAIL stall_first: valid=%b data=%0d", out_valid, v0);
        end
        for (int c = 0; c < 5; c++) begin
          @(negedge clk); #1;
          total++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== v0) begin
            bad++;
            $display("FAIL stall_hold[%0d]: in_ready=%b valid=%b data=%0d required 0/1/%0d",
                     c, in_ready, out_valid, out_data, v0);
          end
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL stall_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL stall_result[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    clear_queues();
  endtask

  task automatic test_saturate();
    bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) send({4{5'd31}}, {4{5'd31}}, (i == 17), 1'b1);
    send({4{5'd1}}, {4{5'd1}}, 1'b0, 1'b0);
    drain(ok);
    total++;
    if (!ok || obs_q.size() != 2 || obs_q[0] !== {1'b1, 16'd65535}) begin
      bad++; $display("FAIL sat_frame: count=%0d first=%h required 2 results, first 0x1ffff",
                      obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 17'h0);
    end
    total++;
    if (obs_q.size() != 2 || obs_q[1] !== {1'b0, 16'd4}) begin
      bad++; $display("FAIL sat_next_frame: got %h required 0x00004",
                      (obs_q.size() > 1) ? obs_q[1] : 17'h0);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL sat_model[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    clear_queues();
  endtask

  task automatic test_back_to_back();
    bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(20'($urandom), 20'($urandom), 1'b0, 1'b0);
    drain(ok);
    total++;
    if (!ok || obs_q.size() != 4) begin
      bad++; $display("FAIL b2b_count: got %0d required 4", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i] || obs_cyc[i] != obs_cyc[0] + i) begin
        bad++;
        $display("FAIL b2b_result[%0d]: got %h at cycle %0d required %h at cycle %0d",
                 i, obs_q[i], obs_cyc[i], exp_q[i], obs_cyc[0] + i);
      end
    end
    clear_queues();
  endtask

  task automatic test_random();
    bit ok;
    bit done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic l;
          l = (i == 39) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
          send(20'($urandom), 20'($urandom), l, 1'($urandom_range(0, 3) != 0));
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        int n = 0;
        while (!done && n < 3000) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 2) != 0);
          n++;
        end
      end
    join
    drain(ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL rand_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL rand_result[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    clear_queues();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int b = 0;
    out_ready = 1'b0;
    send({5'd4, 5'd3, 5'd2, 5'd1}, {5'd8, 5'd7, 5'd6, 5'd5}, 1'b0, 1'b0);
    send(20'($urandom), 20'($urandom), 1'b0, 1'b1);
    send(20'($urandom), 20'($urandom), 1'b0, 1'b1);
    in_valid = 1'b0;
    #1;
    while (out_valid !== 1'b1 && b < 50) begin
      @(negedge clk); #1; b++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 16'd0 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs: valid=%b data=%0d ovf=%b in_ready=%b required 0/0/0/0",
               out_valid, out_data, out_ovf, in_ready);
    end
    clear_queues();
    m_acc = 0;
    m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    send({5'd4, 5'd3, 5'd2, 5'd1}, {5'd8, 5'd7, 5'd6, 5'd5}, 1'b0, 1'b0);
    drain(ok);
    total++;
    if (!ok || obs_q.size() != 1 || obs_q[0] !== {1'b0, 16'd70}) begin
      bad++; $display("FAIL midreset_after: count=%0d first=%h required one result 0x00046",
                      obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 17'h0);
    end
    clear_queues();
  endtask

  initial begin
    test_reset();
    test_single();
    test_accum();
    test_stall();
    test_saturate();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
